// File: rtl/change_flash_pixel.sv
// change_flash_pixel: pixel stage behind the 640x480 VGA timing generator.
// Registers RGB444 and the syncs with one pclk of latency. Once per frame, at the
// vsync falling edge, it samples data_in; a change against the last snapshot
// blinks a rectangular box for FLASH_CYCLES ON/OFF pairs of FLASH_FRAMES frames.
module change_flash_pixel #(
  parameter int          DW           = 12,
  parameter int          FLASH_FRAMES = 8,
  parameter int          FLASH_CYCLES = 3,
  parameter int          BOX_X0       = 0,
  parameter int          BOX_Y0       = 0,
  parameter int          BOX_W        = 64,
  parameter int          BOX_H        = 64,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BOX_COLOR    = 12'h444,
  parameter logic [11:0] FLASH_COLOR  = 12'hF00
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          hsync_i,
  input  logic          vsync_i,
  input  logic          valid_i,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic [DW-1:0] data_in,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic [11:0]   rgb,
  output logic          flashing,
  output logic [7:0]    change_cnt
);

  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int BW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(FLASH_CYCLES - 1);
  localparam logic [10:0]   X_LO = 11'(BOX_X0);
  localparam logic [10:0]   X_HI = 11'(BOX_X0 + BOX_W);
  localparam logic [10:0]   Y_LO = 11'(BOX_Y0);
  localparam logic [10:0]   Y_HI = 11'(BOX_Y0 + BOX_H);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [DW-1:0] snap_q, snap_d;
  logic          armed_q, armed_d;
  logic [7:0]    change_cnt_q, change_cnt_d;
  logic          flashing_q;
  logic          vs_d_q;
  logic          hsync_q, vsync_q;
  logic [11:0]   rgb_q, rgb_d;

  logic [10:0] h_ext, v_ext;
  logic        in_box;
  logic        ftick;
  logic        change_evt;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign in_box = (h_ext >= X_LO) && (h_ext < X_HI) && (v_ext >= Y_LO) && (v_ext < Y_HI);

  assign ftick      = vs_d_q & ~vsync_i;
  assign change_evt = armed_q && (data_in != snap_q);

  // Pixel colour: blank outside active video, box colour follows the blink phase.
  always_comb begin
    rgb_d = 12'h000;
    if (valid_i) begin
      if (in_box) begin
        rgb_d = (state_q == FLASH_ON) ? FLASH_COLOR : BOX_COLOR;
      end else begin
        rgb_d = BG_COLOR;
      end
    end
  end

  // Per-frame snapshot compare and blink sequencing; everything moves only on ftick.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    snap_d       = snap_q;
    armed_d      = armed_q;
    change_cnt_d = change_cnt_q;
    if (ftick) begin
      if (!armed_q) begin
        snap_d  = data_in;
        armed_d = 1'b1;
      end else if (change_evt) begin
        snap_d      = data_in;
        state_d     = FLASH_ON;
        frame_cnt_d = '0;
        blink_cnt_d = '0;
        if (change_cnt_q != 8'hFF) begin
          change_cnt_d = change_cnt_q + 8'd1;
        end
      end else begin
        case (state_q)
          IDLE: state_d = IDLE;
          FLASH_ON: begin
            if (frame_cnt_q == FRAME_LAST) begin
              state_d     = FLASH_OFF;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
          FLASH_OFF: begin
            if (frame_cnt_q == FRAME_LAST) begin
              frame_cnt_d = '0;
              if (blink_cnt_q == BLINK_LAST) begin
                state_d     = IDLE;
                blink_cnt_d = '0;
              end else begin
                state_d     = FLASH_ON;
                blink_cnt_d = blink_cnt_q + 1'b1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State, counters, snapshot and the one-cycle output pipeline.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      snap_q       <= '0;
      armed_q      <= 1'b0;
      change_cnt_q <= 8'd0;
      flashing_q   <= 1'b0;
      vs_d_q       <= 1'b1;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      rgb_q        <= 12'h000;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      snap_q       <= snap_d;
      armed_q      <= armed_d;
      change_cnt_q <= change_cnt_d;
      flashing_q   <= (state_d != IDLE);
      vs_d_q       <= vsync_i;
      hsync_q      <= hsync_i;
      vsync_q      <= vsync_i;
      rgb_q        <= rgb_d;
    end
  end

  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;
  assign rgb        = rgb_q;
  assign flashing   = flashing_q;
  assign change_cnt = change_cnt_q;

endmodule
